pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 63, max cycles in MDU_WAIT before forced release (1..63).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: rs1_d, rs2_d  in  5 each  decode-stage source regs; rs1_e, rs2_e, rd_e  in  5 each  execute-stage regs.
REQ-004 SHALL have ports: rd_m, rd_w  in  5 each  dest regs in M/W; reg_write_m, reg_write_w  in  1 each  write enables.
REQ-005 SHALL have ports: load_e  in  1  E-stage instr is a load; pc_src_e  in  1  branch/jump taken in E; mdu_op_e  in  1  E-stage instr is multi-cycle mul/div; mdu_done  in  1  MDU result valid pulse.
REQ-006 SHALL have ports: stall_f, stall_d, stall_e  out  1 each; flush_d, flush_e, flush_m  out  1 each  pipeline-register enables/clears.
REQ-007 SHALL have ports: forward_a_e, forward_b_e  out  2 each  ALU operand source; mdu_start  out  1  one-cycle MDU launch; mdu_timeout  out  1  one-cycle timeout pulse; stall_count  out  32  cumulative stall cycles.

Function
REQ-008 SHALL encode forwarding: 2'b10 when reg_write_m, rd_m!=0, rd_m==rs*_e; else 2'b01 when reg_write_w, rd_w!=0, rd_w==rs*_e; else 2'b00; M has priority over W.
REQ-009 SHALL compute forwarding combinationally from current inputs, zero latency, identical in all states.
REQ-010 SHALL define lw_stall = load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-011 SHALL implement FSM states START, RUN, MDU_WAIT; START is the reset state.
REQ-012 START: SHALL assert flush_d and flush_e for exactly one cycle, then go to RUN.
REQ-013 RUN: stall_f=stall_d=lw_stall; flush_d=pc_src_e; flush_e=lw_stall|pc_src_e; stall_e=flush_m=0.
REQ-014 RUN with mdu_op_e=1 and pc_src_e=0: SHALL assert mdu_start for that cycle and go to MDU_WAIT next cycle; mdu_op_e with pc_src_e=1 is ignored (instruction squashed).
REQ-015 MDU_WAIT: SHALL assert stall_f, stall_d, stall_e, flush_m; flush_d=flush_e=0; lw_stall and pc_src_e ignored.
REQ-016 MDU_WAIT with mdu_done=1: SHALL deassert all stalls in that same cycle and return to RUN.
REQ-017 MDU_WAIT SHALL count cycles from 1; when count reaches MDU_TIMEOUT without mdu_done, SHALL pulse mdu_timeout, drop stalls that cycle, return to RUN; mdu_done on the same cycle takes precedence (no timeout pulse).
REQ-018 mdu_done in RUN or START SHALL be ignored.
REQ-019 stall_count SHALL increment by 1 each cycle stall_f=1, saturating at 32'hFFFF_FFFF.
REQ-020 Outputs other than forward_* and stall_count SHALL be decoded from state plus current inputs (Mealy), glitch tolerance not required.

Reset
REQ-021 reset=0 SHALL asynchronously force state START, timeout counter 0, stall_count 0.
REQ-022 During reset all stall_*, flush_m, mdu_start, mdu_timeout SHALL be 0; flush_d, flush_e SHALL be 1.
REQ-023 Reset asserted mid-MDU_WAIT SHALL abandon the operation with no mdu_timeout pulse.

Structure
REQ-024 Shared package SHALL hold the forwarding-select constants (FWD_RF, FWD_W, FWD_M) and FSM state encoding.
REQ-025 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated twice (operand A, B).

Verification
REQ-026 Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=2'b10; rd_m=0 -> 2'b01.
REQ-027 Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 one cycle, stall_count +1; rd_e=0 -> no stall.
REQ-028 Branch+load-use same cycle: pc_src_e=1, lw_stall=1 -> flush_d=flush_e=1, stall_f=1.
REQ-029 MDU: mdu_op_e=1 in RUN -> mdu_start pulse; mdu_done 4 cycles later -> stall_f/d/e and flush_m high exactly 4 cycles, stall_count +4.
REQ-030 Timeout: MDU_TIMEOUT=8, no mdu_done -> mdu_timeout pulse on 8th MDU_WAIT cycle, RUN next cycle.
REQ-031 Reset release -> flush_d=flush_e=1 for one cycle (START), then RUN outputs; reset mid-MDU_WAIT -> START, stall_count=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects
// and the sequencing FSM encoding.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one E-stage source register; the M-stage
// producer wins over the W-stage producer because it is the younger write.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_sel_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stalls, branch
// flushes and a stall window around multi-cycle MDU operations with timeout.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic        load_e,
    input  logic        pc_src_e,
    input  logic        mdu_op_e,
    input  logic        mdu_done,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        mdu_start,
    output logic        mdu_timeout,
    output logic [31:0] stall_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MDU_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_count_q, stall_count_d;
    logic             lw_stall;
    logic             tmo_hit;

    fwd_unit u_fwd_a (
        .rs_e_i        (rs1_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (reg_write_m),
        .reg_write_w_i (reg_write_w),
        .fwd_sel_o     (forward_a_e)
    );

    fwd_unit u_fwd_b (
        .rs_e_i        (rs2_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (reg_write_m),
        .reg_write_w_i (reg_write_w),
        .fwd_sel_o     (forward_b_e)
    );

    assign lw_stall = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // cnt_q holds the 1-based index of the current MDU_WAIT cycle.
    assign tmo_hit  = (state_q == MDU_WAIT) && !mdu_done && (cnt_q == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= START;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            START: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (mdu_op_e && !pc_src_e) begin
                    state_d = MDU_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            MDU_WAIT: begin
                if (mdu_done || tmo_hit) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = START;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        mdu_start   = 1'b0;
        mdu_timeout = 1'b0;
        case (state_q)
            START: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            RUN: begin
                stall_f   = lw_stall;
                stall_d   = lw_stall;
                flush_d   = pc_src_e;
                flush_e   = lw_stall || pc_src_e;
                mdu_start = mdu_op_e && !pc_src_e;
            end
            MDU_WAIT: begin
                // The release cycle (done or timeout) already lets the pipe advance.
                if (!mdu_done && !tmo_hit) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
                mdu_timeout = tmo_hit;
            end
            default: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_f && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_write_m, reg_write_w, load_e, pc_src_e, mdu_op_e, mdu_done;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        mdu_start, mdu_timeout;
    logic [31:0] stall_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .load_e      (load_e),
        .pc_src_e    (pc_src_e),
        .mdu_op_e    (mdu_op_e),
        .mdu_done    (mdu_done),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .mdu_start   (mdu_start),
        .mdu_timeout (mdu_timeout),
        .stall_count (stall_count)
    );

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        sf, sd, se, fd, fe, fm, start, tmo;
        logic [31:0] sc;
    } outs_t;

    typedef struct {
        logic [4:0] rs1_e, rs2_e, rd_m, rd_w, rd_e, rs1_d, rs2_d;
        logic       rw_m, rw_w, ld, pc;
        logic [1:0] fa, fb;
        logic       sf, fd, fe;
    } vec_t;

    // Reference model: pipeline "has started", "an MDU op is outstanding",
    // which wait cycle we are in, and the total of stalled cycles.
    bit              m_started;
    bit              m_busy;
    int              m_wait;
    longint unsigned m_stalls;

    task automatic model_reset();
        m_started = 1'b0;
        m_busy    = 1'b0;
        m_wait    = 0;
        m_stalls  = 0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic outs_t model_expect();
        outs_t e;
        bit lw;
        e    = '0;
        e.fa = fwd_ref(rs1_e);
        e.fb = fwd_ref(rs2_e);
        e.sc = (m_stalls > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : m_stalls[31:0];
        lw   = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        if (!m_started) begin
            e.fd = 1'b1;
            e.fe = 1'b1;
        end else if (m_busy) begin
            if (!mdu_done) begin
                if (m_wait == TMO) begin
                    e.tmo = 1'b1;
                end else begin
                    e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.fm = 1'b1;
                end
            end
        end else begin
            e.sf    = lw;
            e.sd    = lw;
            e.fd    = pc_src_e;
            e.fe    = lw || pc_src_e;
            e.start = mdu_op_e && !pc_src_e;
        end
        return e;
    endfunction

    task automatic model_advance(input outs_t e);
        if (!reset) begin
            model_reset();
            return;
        end
        if (e.sf) m_stalls++;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_busy) begin
            if (mdu_done || m_wait == TMO) m_busy = 1'b0;
            else m_wait++;
        end else if (e.start) begin
            m_busy = 1'b1;
            m_wait = 1;
        end
    endtask

    function automatic outs_t actual();
        outs_t o;
        o.fa = forward_a_e; o.fb = forward_b_e;
        o.sf = stall_f; o.sd = stall_d; o.se = stall_e;
        o.fd = flush_d; o.fe = flush_e; o.fm = flush_m;
        o.start = mdu_start; o.tmo = mdu_timeout; o.sc = stall_count;
        return o;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("fa=%0d fb=%0d sf=%0b sd=%0b se=%0b fd=%0b fe=%0b fm=%0b start=%0b tmo=%0b sc=%0d",
                         o.fa, o.fb, o.sf, o.sd, o.se, o.fd, o.fe, o.fm, o.start, o.tmo, o.sc);
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic quiet();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {reg_write_m, reg_write_w, load_e, pc_src_e, mdu_op_e, mdu_done} = '0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the negedge: compare against the model, then take the clock edge.
    task automatic model_step(input string name);
        outs_t e;
        if (!reset) model_reset();
        e = model_expect();
        check_outs(name, e);
        model_advance(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string name);
        settle();
        model_step(name);
    endtask

    vec_t        tbl[12];
    logic [31:0] sc0;

    initial begin
        tbl[0]  = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{5'd3, 5'd9, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{5'd12, 5'd12, 5'd12, 5'd12, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{5'd7, 5'd8, 5'd7, 5'd8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        quiet();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, then the one START cycle, then RUN.
        settle();
        check_bit("rst_flush_d", flush_d, 1'b1);
        check_bit("rst_flush_e", flush_e, 1'b1);
        check_bit("rst_stall_f", stall_f, 1'b0);
        check_val("rst_stall_count", stall_count, 32'd0);
        model_step("reset_hold");
        reset = 1'b1;
        settle();
        check_bit("start_flush_e", flush_e, 1'b1);
        model_step("start");
        settle();
        check_bit("run_flush_d", flush_d, 1'b0);
        model_step("run_first");

        // Directed combinational vectors in RUN.
        for (int i = 0; i < 12; i++) begin
            outs_t e;
            rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e;
            rd_m = tbl[i].rd_m; rd_w = tbl[i].rd_w; rd_e = tbl[i].rd_e;
            rs1_d = tbl[i].rs1_d; rs2_d = tbl[i].rs2_d;
            reg_write_m = tbl[i].rw_m; reg_write_w = tbl[i].rw_w;
            load_e = tbl[i].ld; pc_src_e = tbl[i].pc;
            settle();
            e    = '0;
            e.fa = tbl[i].fa; e.fb = tbl[i].fb;
            e.sf = tbl[i].sf; e.sd = tbl[i].sf;
            e.fd = tbl[i].fd; e.fe = tbl[i].fe;
            e.sc = m_stalls[31:0];
            check_outs($sformatf("table[%0d]", i), e);
            model_advance(model_expect());
            @(posedge clk);
            #1;
        end

        // Load-use adds exactly one stall cycle.
        quiet();
        sc0 = stall_count;
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        cyc("lw_cycle");
        quiet();
        settle();
        check_val("lw_stall_count_inc", stall_count, sc0 + 32'd1);
        model_step("lw_after");

        // MDU op completed after four stalled cycles.
        mdu_op_e = 1'b1;
        settle();
        check_bit("mdu_start_pulse", mdu_start, 1'b1);
        check_bit("mdu_start_no_stall", stall_f, 1'b0);
        model_step("mdu_launch");
        mdu_op_e = 1'b0;
        sc0 = stall_count;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
            end else begin
                quiet();
            end
            settle();
            check_bit("mdu_wait_stall_e", stall_e, 1'b1);
            check_bit("mdu_wait_flush_m", flush_m, 1'b1);
            check_bit("mdu_wait_flush_d", flush_d, 1'b0);
            model_step("mdu_wait");
        end
        quiet();
        mdu_done = 1'b1;
        settle();
        check_bit("mdu_done_release", stall_f, 1'b0);
        check_bit("mdu_done_no_tmo", mdu_timeout, 1'b0);
        model_step("mdu_done");
        mdu_done = 1'b0;
        settle();
        check_val("mdu_stall_count_plus4", stall_count, sc0 + 32'd4);
        check_bit("mdu_back_in_run", stall_f, 1'b0);
        model_step("mdu_after");

        // MDU op squashed by a taken branch.
        mdu_op_e = 1'b1; pc_src_e = 1'b1;
        settle();
        check_bit("mdu_squashed_no_start", mdu_start, 1'b0);
        model_step("mdu_squash");
        quiet();
        settle();
        check_bit("mdu_squash_still_run", stall_e, 1'b0);
        model_step("mdu_squash_after");

        // Timeout on the TMO-th wait cycle.
        mdu_op_e = 1'b1;
        cyc("tmo_launch");
        mdu_op_e = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            settle();
            check_bit("tmo_not_yet", mdu_timeout, 1'b0);
            model_step("tmo_wait");
        end
        settle();
        check_bit("tmo_pulse", mdu_timeout, 1'b1);
        check_bit("tmo_release", stall_f, 1'b0);
        model_step("tmo_cycle");
        settle();
        check_bit("tmo_one_shot", mdu_timeout, 1'b0);
        check_bit("tmo_run_flush_m", flush_m, 1'b0);
        model_step("tmo_after");

        // mdu_done on the timeout cycle suppresses the pulse.
        mdu_op_e = 1'b1;
        cyc("tmo2_launch");
        mdu_op_e = 1'b0;
        for (int i = 1; i < TMO; i++) cyc("tmo2_wait");
        mdu_done = 1'b1;
        settle();
        check_bit("done_beats_tmo", mdu_timeout, 1'b0);
        model_step("tmo2_done");
        mdu_done = 1'b0;
        cyc("tmo2_after");

        // Reset in the middle of an MDU wait.
        mdu_op_e = 1'b1;
        cyc("rstw_launch");
        mdu_op_e = 1'b0;
        cyc("rstw_wait1");
        cyc("rstw_wait2");
        reset = 1'b0;
        settle();
        check_bit("rstw_no_tmo", mdu_timeout, 1'b0);
        check_bit("rstw_no_stall", stall_f, 1'b0);
        check_val("rstw_stall_count", stall_count, 32'd0);
        model_step("rstw_hold");
        reset = 1'b1;
        settle();
        check_bit("rstw_start_flush_d", flush_d, 1'b1);
        model_step("rstw_start");
        settle();
        check_bit("rstw_run_flush_d", flush_d, 1'b0);
        model_step("rstw_run");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            load_e   = ($urandom_range(0, 2) == 0);
            pc_src_e = ($urandom_range(0, 5) == 0);
            mdu_op_e = ($urandom_range(0, 4) == 0);
            mdu_done = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 299) != 0);
            cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
